// File: rtl/bank_htu_lookup_arb.sv
// bank_htu_lookup_arb: round-robin arbiter feeding a one-entry issue stage
// that strobes one bank HTU set-status instance per lookup.
// Optional feature macro: BANK_HTU_LOOKUP_ARB_PERF_EN adds per-requester
// 16-bit saturating grant counters (gnt_cnt_o) with a clear input (cnt_clr_i).
module bank_htu_lookup_arb #(
    parameter int NUM_REQ = 4,
    parameter int NUM_SET = 8,
    localparam int IDW = $clog2(NUM_REQ),
    localparam int SW  = $clog2(NUM_SET)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_vld_i,
    input  logic [32*NUM_REQ-1:0]  req_addr_i,
    output logic [NUM_REQ-1:0]     req_rdy_o,
    input  logic                   htu_rdy_i,
    input  logic                   flush_i,
    output logic [NUM_SET-1:0]     set_hit_o,
    output logic [21:0]            set_tag_o,
    output logic                   offset_o,
    output logic [IDW-1:0]         iss_id_o,
    output logic                   iss_fire_o
`ifdef BANK_HTU_LOOKUP_ARB_PERF_EN
    ,
    input  logic                   cnt_clr_i,
    output logic [16*NUM_REQ-1:0]  gnt_cnt_o
`endif
);

    logic            iss_vld_q, iss_vld_d;
    logic [31:6]     iss_addr_q, iss_addr_d;
    logic [IDW-1:0]  iss_id_q, iss_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

    logic            accept;
    logic            fire;
    logic            found;
    logic [IDW-1:0]  winner;

    // Reset masks the handshakes so nothing is granted or issued while it is held.
    always_comb begin
        accept = ~rst_i & ~flush_i & (~iss_vld_q | htu_rdy_i);
        fire   = ~rst_i & iss_vld_q & htu_rdy_i & ~flush_i;
    end

    // Scan requesters upward from the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin : p_arb
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_vld_i[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // Grant strobe, set strobe and the issued-entry fields seen by the status array.
    always_comb begin
        req_rdy_o  = '0;
        set_hit_o  = '0;
        if (accept && found) begin
            req_rdy_o = NUM_REQ'(1) << winner;
        end
        if (fire) begin
            set_hit_o = NUM_SET'(1) << iss_addr_q[6+SW:7];
        end
        iss_fire_o = fire;
        set_tag_o  = iss_addr_q[31:10];
        offset_o   = iss_addr_q[6];
        iss_id_o   = iss_id_q;
    end

    // Next state: a new grant replaces the entry that fires this cycle; flush only empties it.
    always_comb begin
        iss_vld_d  = iss_vld_q;
        iss_addr_d = iss_addr_q;
        iss_id_d   = iss_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (flush_i) begin
            iss_vld_d = 1'b0;
        end else if (accept && found) begin
            iss_vld_d  = 1'b1;
            iss_addr_d = req_addr_i[32*winner+6 +: 26];
            iss_id_d   = winner;
            rr_ptr_d   = (int'(winner) == NUM_REQ-1) ? '0 : winner + 1'b1;
        end else if (fire) begin
            iss_vld_d = 1'b0;
        end
    end

    // Issue-stage and pointer registers; reset discards any pending entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iss_vld_q  <= 1'b0;
            iss_addr_q <= '0;
            iss_id_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            iss_vld_q  <= iss_vld_d;
            iss_addr_q <= iss_addr_d;
            iss_id_q   <= iss_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifdef BANK_HTU_LOOKUP_ARB_PERF_EN
    logic [15:0] gnt_cnt_q [NUM_REQ];

    // Per-requester grant counters; clear beats a same-cycle increment and counts saturate.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_i || cnt_clr_i) begin
                gnt_cnt_q[i] <= '0;
            end else if (req_rdy_o[i] && gnt_cnt_q[i] != 16'hFFFF) begin
                gnt_cnt_q[i] <= gnt_cnt_q[i] + 16'd1;
            end
        end
    end

    // Flatten the counters, requester i at [16*i+:16].
    always_comb begin
        gnt_cnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_cnt_o[16*i +: 16] = gnt_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_bank_htu_lookup_arb.sv
// Testbench for bank_htu_lookup_arb: a cycle model predicts grants and fires,
// the pending issue entry lives in a scoreboard queue and is compared when it fires.
module tb_bank_htu_lookup_arb;

    localparam int NR = 4;
    localparam int NS = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     reqVld;
    logic [32*NR-1:0]  reqAddr;
    logic [NR-1:0]     reqRdy;
    logic              htuRdy;
    logic              flush;
    logic [NS-1:0]     setHit;
    logic [21:0]       setTag;
    logic              offset;
    logic [1:0]        issId;
    logic              issFire;
`ifdef BANK_HTU_LOOKUP_ARB_PERF_EN
    logic              cntClr;
    logic [16*NR-1:0]  gntCnt;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
    } entry_t;

    entry_t sb[$];
    int     fireLog[$];
    logic   mVld;
    logic [1:0] mPtr;
    int     checks = 0;
    int     errors = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    bank_htu_lookup_arb #(.NUM_REQ(NR), .NUM_SET(NS)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_vld_i  (reqVld),
        .req_addr_i (reqAddr),
        .req_rdy_o  (reqRdy),
        .htu_rdy_i  (htuRdy),
        .flush_i    (flush),
        .set_hit_o  (setHit),
        .set_tag_o  (setTag),
        .offset_o   (offset),
        .iss_id_o   (issId),
        .iss_fire_o (issFire)
`ifdef BANK_HTU_LOOKUP_ARB_PERF_EN
        ,
        .cnt_clr_i  (cntClr),
        .gnt_cnt_o  (gntCnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus();
        logic       accept;
        logic       found;
        logic       fire;
        int         w;
        logic [NR-1:0] expRdy;
        entry_t     e;
        @(negedge clk);
        accept = !flush && (!mVld || htuRdy);
        found  = 1'b0;
        w      = 0;
        for (int k = 0; k < NR; k++) begin
            int idx = (int'(mPtr) + k) % NR;
            if (!found && reqVld[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        expRdy = (!rst && accept && found) ? (NR'(1) << w) : '0;
        fire   = !rst && mVld && htuRdy && !flush;
        checkOutput("req_rdy", 64'(reqRdy), 64'(expRdy));
        checkOutput("iss_fire", 64'(issFire), 64'(fire));
        if (fire && sb.size() > 0) begin
            e = sb[0];
            checkOutput("set_hit", 64'(setHit), 64'(NS'(1) << e.addr[9:7]));
            fireLog.push_back(int'(issId));
        end else begin
            checkOutput("set_hit_idle", 64'(setHit), 64'd0);
        end
        if (mVld && sb.size() > 0) begin
            e = sb[0];
            checkOutput("iss_id", 64'(issId), 64'(e.id));
            checkOutput("set_tag", 64'(setTag), 64'(e.addr[31:10]));
            checkOutput("offset", 64'(offset), 64'(e.addr[6]));
        end
        if (rst) begin
            mVld = 1'b0;
            mPtr = '0;
            sb.delete();
        end else if (flush) begin
            mVld = 1'b0;
            sb.delete();
        end else begin
            if (fire) begin
                void'(sb.pop_front());
                mVld = 1'b0;
            end
            if (accept && found) begin
                e.id   = 2'(w);
                e.addr = reqAddr[32*w +: 32];
                sb.push_back(e);
                mVld = 1'b1;
                mPtr = (w == NR-1) ? 2'd0 : 2'(w + 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios, a random phase, then the optional counter checks.
    initial begin
        rst     = 1'b1;
        reqVld  = '1;
        htuRdy  = 1'b1;
        flush   = 1'b0;
        reqAddr = {32'h4000_0180, 32'h3000_0300, 32'h2000_0080, 32'h1000_0040};
        mVld    = 1'b0;
        mPtr    = '0;
`ifdef BANK_HTU_LOOKUP_ARB_PERF_EN
        cntClr  = 1'b0;
`endif

        $display("[TB] reset");
        applyStimulus();
        #1;
        checkOutput("rst_req_rdy", 64'(reqRdy), 64'd0);
        checkOutput("rst_set_hit", 64'(setHit), 64'd0);
        checkOutput("rst_set_tag", 64'(setTag), 64'd0);
        checkOutput("rst_offset", 64'(offset), 64'd0);
        checkOutput("rst_iss_id", 64'(issId), 64'd0);
        checkOutput("rst_iss_fire", 64'(issFire), 64'd0);
        applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("first_grant", 64'(reqRdy), 64'b0001);

        $display("[TB] round robin");
        fireLog.delete();
        repeat (9) applyStimulus();
        checkOutput("rr_count", 64'(fireLog.size() >= 8), 64'd1);
        for (int i = 0; i < 8 && i < fireLog.size(); i++) begin
            checkOutput("rr_seq", 64'(fireLog[i]), 64'(i % 4));
        end
        reqVld = '0;
        applyStimulus();

        $display("[TB] backpressure");
        reqAddr[64 +: 32] = 32'h1234_5680;
        reqVld = 4'b0100;
        applyStimulus();
        reqVld = 4'b1111;
        htuRdy = 1'b0;
        repeat (5) begin
            #1;
            checkOutput("bp_req_rdy", 64'(reqRdy), 64'd0);
            checkOutput("bp_set_tag", 64'(setTag), 64'h048D15);
            checkOutput("bp_offset", 64'(offset), 64'd0);
            checkOutput("bp_no_hit", 64'(setHit), 64'd0);
            applyStimulus();
        end
        htuRdy = 1'b1;
        #1;
        checkOutput("bp_hit", 64'(setHit), 64'b0010_0000);
        applyStimulus();
        reqVld = '0;
        applyStimulus();

        $display("[TB] sparse wrap");
        reqVld = 4'b0100;
        applyStimulus();
        reqVld = 4'b0101;
        #1;
        checkOutput("wrap_g0", 64'(reqRdy), 64'b0001);
        applyStimulus();
        #1;
        checkOutput("wrap_g2", 64'(reqRdy), 64'b0100);
        applyStimulus();
        #1;
        checkOutput("wrap_g0b", 64'(reqRdy), 64'b0001);
        applyStimulus();

        $display("[TB] flush");
        flush = 1'b1;
        #1;
        checkOutput("flush_hit", 64'(setHit), 64'd0);
        checkOutput("flush_rdy", 64'(reqRdy), 64'd0);
        applyStimulus();
        flush = 1'b0;
        #1;
        checkOutput("post_flush_hit", 64'(setHit), 64'd0);
        checkOutput("post_flush_rdy", 64'(reqRdy), 64'b0100);
        applyStimulus();
        reqVld = '0;
        applyStimulus();

        $display("[TB] reset in flight");
        reqVld = 4'b0001;
        applyStimulus();
        reqVld = '0;
        rst = 1'b1;
        #1;
        checkOutput("rst_fly_hit", 64'(setHit), 64'd0);
        applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("rst_fly_fire", 64'(issFire), 64'd0);
        applyStimulus();

        $display("[TB] random");
        for (int n = 0; n < 300; n++) begin
            rst    = ($urandom_range(0, 49) == 0);
            flush  = ($urandom_range(0, 9) == 0);
            htuRdy = ($urandom_range(0, 3) != 0);
            reqVld = NR'($urandom);
            for (int r = 0; r < NR; r++) begin
                reqAddr[32*r +: 32] = $urandom;
            end
            applyStimulus();
        end
        rst = 1'b0;
        flush = 1'b0;
        reqVld = '0;
        applyStimulus();

`ifdef BANK_HTU_LOOKUP_ARB_PERF_EN
        $display("[TB] grant counters");
        htuRdy = 1'b1;
        reqVld = 4'b0010;
        repeat (70000) @(posedge clk);
        #1;
        checkOutput("cnt_sat", 64'(gntCnt[31:16]), 64'hFFFF);
        cntClr = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("cnt_clr", 64'(gntCnt[31:16]), 64'd0);
        cntClr = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("cnt_inc", 64'(gntCnt[31:16]), 64'd1);
        reqVld = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
